cordic_quad_map: RTL and testbench
==================================

CORDIC_QUAD_MAP -- requirements
Module: cordic_quad_map

Interface
REQ-001 Parameter DW, default 16, signed width of X/Y samples.
REQ-002 Parameter AW, default 14, signed width of angle words.
REQ-003 Parameter PI_CODE, default 2^(AW-1)-1, angle code representing +pi.
REQ-004 Parameter DEPTH, default 16, power of two >= 2, tag FIFO depth (covers the downstream CORDIC latency).
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid / in_ready  in / out  1 / 1  input handshake.
- x_in, y_in  in  DW  signed input vector.
- map_valid / map_ready  out / in  1 / 1  handshake toward the CORDIC.
- x_map, y_map  out  DW  mapped vector with X >= 0.
- ang_valid / ang_ready  in / out  1 / 1  handshake from the CORDIC.
- ang_in  in  AW  signed CORDIC angle for the mapped vector.
- out_valid / out_ready  out / in  1 / 1  output handshake.
- ang_out  out  AW  corrected full-circle angle.
- quad_out  out  1  1 = sample was reflected.
- err  out  1  sticky protocol-error flag.

Function
REQ-006 Input transfer occurs when in_valid && in_ready; the map transfer, angle transfer and output transfer follow the same valid && ready rule.
REQ-007 in_ready = (map register empty or map_ready) and (FIFO count < DEPTH); it has no combinational path from the pop side.
REQ-008 Map stage:
- 1-cycle registered latency.
- If x_in[DW-1] = 0: x_map = x_in, y_map = y_in, tag = 0.
- Otherwise: x_map = -x_in, y_map = -y_in, tag = 1.
REQ-009 Negation of the most-negative code (-2^(DW-1)) saturates to 2^(DW-1)-1; this applies to X and Y independently.
REQ-010 The tag is pushed into the tag FIFO in the same cycle as the input transfer, in arrival order.
REQ-011 A held map word stays stable while map_valid && !map_ready.
REQ-012 ang_ready = FIFO not empty and (output register empty or out_ready).
REQ-013 The angle transfer pops one tag; the output is registered with 1-cycle latency.
REQ-014 Angle correction:
- tag 0: ang_out = ang_in.
- tag 1 and ang_in > 0: ang_out = ang_in - PI_CODE.
- tag 1 and ang_in <= 0: ang_out = ang_in + PI_CODE.
- Arithmetic in AW+1 bits, truncated to AW; no wrap is possible within range.
REQ-015 quad_out carries the popped tag alongside ang_out.
REQ-016 An ang_valid asserted while the FIFO is empty for 1 cycle sets err; err stays set until reset and the angle is not consumed.
REQ-017 Simultaneous push and pop in one cycle is legal; the count is unchanged.
REQ-018 When the FIFO is full, the push is refused even if a pop occurs in the same cycle (follows from REQ-007).
REQ-019 The FIFO pointers wrap modulo DEPTH.

Reset
REQ-020 While rst = 1, at the clock edge:
- map_valid, out_valid, err, quad_out := 0.
- x_map, y_map, ang_out := 0.
- FIFO count and both pointers := 0.
REQ-021 During reset in_ready and ang_ready are 0; any in-flight sample or tag is discarded, including one caught mid-transfer.
REQ-022 The first input transfer is possible in the first cycle after rst deasserts.

Structure
REQ-023 A shared package cordic_pkg holds the default DW, AW and PI_CODE and a quadrant-tag typedef; DEPTH stays local.
REQ-024 The tag FIFO is one sub-module, tag_fifo (parameters DEPTH and width 1, synchronous, with full, empty and count outputs).
REQ-025 The map stage and the correct stage are inline registered logic in cordic_quad_map.

Verification
REQ-026 Vector (x=-100, y=50); CORDIC returns ang_in=-0.4636 rad code -> x_map=100, y_map=-50, ang_out=ang_in+PI_CODE, quad_out=1.
REQ-027 Vector (x=-100, y=0) with ang_in=0 -> ang_out=PI_CODE; vector (x=-32768, y=-32768) with DW=16 -> x_map=y_map=32767.
REQ-028 Send 16 inputs with ang_valid held 0 -> in_ready drops after the 16th push; one angle pop plus one new push the next cycle -> count stays 16, tag order preserved.
REQ-029 Hold map_ready=0 and out_ready=0 for 5 cycles -> held outputs are stable and no transfers are lost; release both -> in-order drain.
REQ-030 ang_valid=1 immediately after reset -> err=1 the next cycle and stays 1; a mid-stream rst pulse -> all valids 0, count 0 the next cycle.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC quadrant mapper.
// Holds the default sample width, the default angle width, the default +pi
// angle code and the quadrant-tag type. The tag FIFO depth is not kept here;
// each instance chooses its own depth.
package cordic_pkg;

    localparam int DW_DEF      = 16;
    localparam int AW_DEF      = 14;
    localparam int PI_CODE_DEF = (1 << (AW_DEF - 1)) - 1;

    // Records whether a sample was reflected through the origin before the CORDIC.
    typedef enum logic {
        QUAD_DIRECT  = 1'b0,
        QUAD_REFLECT = 1'b1
    } quad_tag_t;

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO for the quadrant tags.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   push, din         write request and data (ignored while full)
//   pop, dout         read request (ignored while empty); dout shows the head
//   full, empty       occupancy flags
//   count             number of stored entries, 0..DEPTH
module tag_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the reset pointers make every entry invalid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/cordic_quad_map.sv
// Quadrant pre-map and post-correction around a right-half-plane CORDIC.
// Samples with negative X are reflected through the origin (both components
// negated, with saturation of the most-negative code) so the CORDIC only sees
// X >= 0. A tag per sample goes into a FIFO and is used to add or subtract
// pi from the angle the CORDIC returns, restoring the full-circle angle.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready, x_in, y_in     input vector handshake
//   map_valid/map_ready, x_map, y_map mapped vector toward the CORDIC
//   ang_valid/ang_ready, ang_in       angle handshake from the CORDIC
//   out_valid/out_ready, ang_out,     corrected angle and reflection flag
//   quad_out
//   err                               sticky: angle arrived with no tag pending
module cordic_quad_map
    import cordic_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int PI_CODE = (AW == AW_DEF) ? PI_CODE_DEF : (1 << (AW - 1)) - 1,
    parameter int DEPTH   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x_in,
    input  logic [DW-1:0] y_in,
    output logic          map_valid,
    input  logic          map_ready,
    output logic [DW-1:0] x_map,
    output logic [DW-1:0] y_map,
    input  logic          ang_valid,
    output logic          ang_ready,
    input  logic [AW-1:0] ang_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] ang_out,
    output logic          quad_out,
    output logic          err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] SMIN   = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] SMAX   = ~SMIN;
    localparam logic [AW:0]   PI_EXT = (AW+1)'(PI_CODE);

    logic          fifo_full, fifo_empty, fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          push, pop;
    quad_tag_t     tag_in;

    logic          map_valid_q, map_valid_d;
    logic [DW-1:0] x_map_q, x_map_d, y_map_q, y_map_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] ang_out_q, ang_out_d;
    logic          quad_q, quad_d;
    logic          err_q, err_d;

    logic [DW-1:0] x_neg, y_neg;
    logic [AW:0]   ang_ext, ang_sum;
    logic          ang_pos;

    // Readiness depends only on registered state and the downstream ready,
    // never on the pop side of the FIFO, so a full FIFO refuses a push even
    // in a cycle that also pops.
    assign in_ready  = !rst && (!map_valid_q || map_ready) && (fifo_count < CW'(DEPTH));
    assign ang_ready = !rst && !fifo_empty && (!out_valid_q || out_ready);
    assign push      = in_valid && in_ready && !fifo_full;
    assign pop       = ang_valid && ang_ready;
    assign tag_in    = x_in[DW-1] ? QUAD_REFLECT : QUAD_DIRECT;

    tag_fifo #(
        .DEPTH (DEPTH),
        .W     (1)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (tag_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // -(-2^(DW-1)) is not representable; clamp it to the largest positive code.
    assign x_neg = (x_in == SMIN) ? SMAX : (~x_in + 1'b1);
    assign y_neg = (y_in == SMIN) ? SMAX : (~y_in + 1'b1);

    assign ang_ext = {ang_in[AW-1], ang_in};
    assign ang_pos = !ang_in[AW-1] && (ang_in != '0);
    assign ang_sum = ang_pos ? (ang_ext - PI_EXT) : (ang_ext + PI_EXT);

    always_comb begin
        map_valid_d = map_valid_q;
        x_map_d     = x_map_q;
        y_map_d     = y_map_q;
        out_valid_d = out_valid_q;
        ang_out_d   = ang_out_q;
        quad_d      = quad_q;
        err_d       = err_q | (ang_valid && fifo_empty);

        if (push) begin
            map_valid_d = 1'b1;
            x_map_d     = x_in[DW-1] ? x_neg : x_in;
            y_map_d     = x_in[DW-1] ? y_neg : y_in;
        end else if (map_ready) begin
            map_valid_d = 1'b0;
        end

        if (pop) begin
            out_valid_d = 1'b1;
            ang_out_d   = fifo_dout ? ang_sum[AW-1:0] : ang_in;
            quad_d      = fifo_dout;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            map_valid_q <= 1'b0;
            x_map_q     <= '0;
            y_map_q     <= '0;
            out_valid_q <= 1'b0;
            ang_out_q   <= '0;
            quad_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            map_valid_q <= map_valid_d;
            x_map_q     <= x_map_d;
            y_map_q     <= y_map_d;
            out_valid_q <= out_valid_d;
            ang_out_q   <= ang_out_d;
            quad_q      <= quad_d;
            err_q       <= err_d;
        end
    end

    assign map_valid = map_valid_q;
    assign x_map     = x_map_q;
    assign y_map     = y_map_q;
    assign out_valid = out_valid_q;
    assign ang_out   = ang_out_q;
    assign quad_out  = quad_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cordic_quad_map.sv
module tb_cordic_quad_map;

    localparam int DW    = 16;
    localparam int AW    = 14;
    localparam int DEPTH = 16;
    localparam int PI    = (1 << (AW - 1)) - 1;
    localparam int SMIN  = -(1 << (DW - 1));
    localparam int SMAX  = (1 << (DW - 1)) - 1;

    logic          clk = 1'b0;
    logic          rst, in_valid, map_ready, ang_valid, out_ready;
    logic [DW-1:0] x_in, y_in;
    logic [AW-1:0] ang_in;
    logic          in_ready, map_valid, ang_ready, out_valid, quad_out, err;
    logic [DW-1:0] x_map, y_map;
    logic [AW-1:0] ang_out;

    int passed = 0;
    int total  = 0;

    cordic_quad_map #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .map_valid (map_valid),
        .map_ready (map_ready),
        .x_map     (x_map),
        .y_map     (y_map),
        .ang_valid (ang_valid),
        .ang_ready (ang_ready),
        .ang_in    (ang_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ang_out   (ang_out),
        .quad_out  (quad_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: queues of pending mapped vectors, tags and results.
    typedef struct { int x; int y; } vec_t;
    typedef struct { int a; bit q; } res_t;
    vec_t mq[$];
    bit   tq[$];
    res_t oq[$];
    bit   m_err;

    function automatic int neg_sat(int v);
        return (v == SMIN) ? SMAX : -v;
    endfunction

    function automatic int correct(bit tag, int a);
        if (!tag)  return a;
        if (a > 0) return a - PI;
        return a + PI;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_vec(int x, int y);
        x_in = x[DW-1:0];
        y_in = y[DW-1:0];
    endtask

    task automatic set_ang(int a);
        ang_in = a[AW-1:0];
    endtask

    // Called at a falling edge with inputs already driven; checks all outputs
    // against the model, advances the model by one clock and returns at the
    // next falling edge.
    task automatic step();
        bit   m_inr, m_angr, was_empty;
        vec_t v;
        res_t r;
        int   xi, yi;
        #1;
        m_inr  = !rst && (mq.size() == 0 || map_ready) && (tq.size() < DEPTH);
        m_angr = !rst && (tq.size() > 0) && (oq.size() == 0 || out_ready);
        chk("in_ready",  in_ready,  m_inr);
        chk("ang_ready", ang_ready, m_angr);
        chk("map_valid", map_valid, mq.size() != 0);
        chk("out_valid", out_valid, oq.size() != 0);
        chk("err",       err,       m_err);
        if (mq.size() != 0) begin
            chk("x_map", $signed(x_map), mq[0].x);
            chk("y_map", $signed(y_map), mq[0].y);
        end
        if (oq.size() != 0) begin
            chk("ang_out",  $signed(ang_out), oq[0].a);
            chk("quad_out", quad_out, oq[0].q);
        end
        if (rst) begin
            mq.delete(); tq.delete(); oq.delete();
            m_err = 1'b0;
        end else begin
            was_empty = (tq.size() == 0);
            if (oq.size() != 0 && out_ready) void'(oq.pop_front());
            if (mq.size() != 0 && map_ready) void'(mq.pop_front());
            if (ang_valid && m_angr) begin
                r.q = tq.pop_front();
                r.a = correct(r.q, $signed(ang_in));
                oq.push_back(r);
            end
            if (ang_valid && was_empty) m_err = 1'b1;
            if (in_valid && m_inr) begin
                xi = $signed(x_in);
                yi = $signed(y_in);
                v.x = (xi < 0) ? neg_sat(xi) : xi;
                v.y = (xi < 0) ? neg_sat(yi) : yi;
                mq.push_back(v);
                tq.push_back(xi < 0);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; ang_valid = 0; map_ready = 0; out_ready = 0;
        set_vec(0, 0); set_ang(0);
    endtask

    task automatic do_reset();
        rst = 1; idle(); step(); step();
        rst = 0;
    endtask

    function automatic int rnd_sample();
        int k = int'($urandom_range(0, 9));
        if (k == 0) return SMIN;
        if (k == 1) return SMAX;
        if (k == 2) return 0;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    typedef struct {
        int x, y, a;
        int ex, ey, ea;
        bit eq;
    } vec_rec_t;

    vec_rec_t tbl[9];

    initial begin
        rst = 1; m_err = 0; idle();
        @(negedge clk);

        // (x, y, ang_in) -> (x_map, y_map, ang_out, quad_out); +pi = 8191
        tbl[0] = '{-100,    50,  -1209,   100,    -50,  6982, 1};
        tbl[1] = '{-100,     0,      0,   100,      0,  8191, 1};
        tbl[2] = '{-32768, -32768, 5000, 32767,  32767, -3191, 1};
        tbl[3] = '{ 100,   -50,   1209,   100,    -50,  1209, 0};
        tbl[4] = '{-32768,   5,  -8191, 32767,     -5,     0, 1};
        tbl[5] = '{  -1, -32768,  8191,     1,  32767,     0, 1};
        tbl[6] = '{   0,     0,  -8191,     0,      0, -8191, 0};
        tbl[7] = '{32767, -32768,    1, 32767, -32768,     1, 0};
        tbl[8] = '{  -5,     7,      1,     5,     -7, -8190, 1};

        // Reset state
        do_reset();
        chk("rst_x_map",   x_map,   0);
        chk("rst_y_map",   y_map,   0);
        chk("rst_ang_out", ang_out, 0);
        chk("rst_quad",    quad_out, 0);

        // Table vectors, one at a time through both stages
        foreach (tbl[i]) begin
            in_valid = 1; set_vec(tbl[i].x, tbl[i].y);
            step();
            in_valid = 0;
            chk($sformatf("tbl%0d_x_map", i), $signed(x_map), tbl[i].ex);
            chk($sformatf("tbl%0d_y_map", i), $signed(y_map), tbl[i].ey);
            map_ready = 1; ang_valid = 1; set_ang(tbl[i].a);
            step();
            ang_valid = 0; map_ready = 0;
            chk($sformatf("tbl%0d_ang", i),  $signed(ang_out), tbl[i].ea);
            chk($sformatf("tbl%0d_quad", i), quad_out, tbl[i].eq);
            out_ready = 1;
            step();
            out_ready = 0;
        end

        // Angle with no tag pending: sticky error, angle not consumed
        do_reset();
        ang_valid = 1; set_ang(123);
        step();
        ang_valid = 0;
        chk("err_set", err, 1);
        chk("err_no_out", out_valid, 0);
        for (int i = 0; i < 4; i++) step();
        chk("err_sticky", err, 1);
        do_reset();
        chk("err_cleared", err, 0);

        // Fill the FIFO, then a pop with a refused push, then a push refilling it
        map_ready = 1; out_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; set_vec((i % 3 == 0) ? -100 - i : 100 + i, i);
            step();
        end
        #1 chk("full_in_ready", in_ready, 0);
        ang_valid = 1; set_ang(100); set_vec(-7, 3);
        step();
        ang_valid = 0;
        step();
        in_valid = 0;
        #1 chk("full_after_swap", in_ready, 0);
        ang_valid = 1; set_ang(100);
        for (int i = 0; i < DEPTH + 2; i++) begin
            ang_valid = (tq.size() > 0);
            step();
        end
        ang_valid = 0; step();

        // Downstream stall for 5 cycles with requests pending, then drain
        do_reset();
        in_valid = 1; set_vec(-300, 77);
        step();
        ang_valid = 1; set_ang(-50);
        for (int i = 0; i < 5; i++) begin
            set_vec(400 + i, -i);
            step();
        end
        map_ready = 1; out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            in_valid  = (i < 8);
            set_vec(rnd_sample(), rnd_sample());
            ang_valid = (tq.size() > 0);
            set_ang(int'($urandom_range(0, 2 * PI)) - PI);
            step();
        end

        // Mid-stream reset with transfers in flight
        in_valid = 1; ang_valid = 1; map_ready = 0; out_ready = 0;
        set_vec(-9, 9); step();
        set_vec(-8, 8); step();
        rst = 1; step();
        rst = 0; in_valid = 0; ang_valid = 0;
        chk("mid_rst_map_valid", map_valid, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            set_vec(rnd_sample(), rnd_sample());
            map_ready = $urandom_range(0, 3) != 0;
            ang_valid = (tq.size() > 0) && ($urandom_range(0, 2) != 0);
            set_ang(int'($urandom_range(0, 2 * PI)) - PI);
            out_ready = $urandom_range(0, 3) != 0;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
